data_mem_ctrl: RTL and testbench

Request/response front end for the 32-byte data memory. It sits directly upstream of the memory and accepts one load or store at a time from the execute stage over a valid/ready handshake. It drives the memory's strobe, address and write-data inputs in the sequence the memory needs, because the memory acts only on address events. It then returns read data or an error to the writeback side over a second valid/ready handshake.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/data_mem_ctrl.sv | 116 +++++++++++
 tb/tb_data_mem_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory front end.
//   - state_t   : controller FSM encoding (2 bits)
//   - ADDR_W    : byte address width
//   - DATA_W    : data width
//   - MEM_DEPTH : number of addressable bytes; higher addresses fault
//   - PARK_ADDR : idle address driven to the memory (outside the array)
package mem_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 32;

  localparam logic [ADDR_W-1:0] PARK_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // True when the byte address maps onto a real memory location.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/data_mem_ctrl.sv
// Request/response front end for the 32-byte data memory.
// Accepts one load or store at a time, drives the memory address/strobe
// sequence (park -> target with strobe -> target without strobe -> park),
// and returns read data or an address fault.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   REQ_VALID/REQ_READY   request handshake; REQ_WRITE/REQ_ADDR/REQ_WDATA payload
//   RESP_VALID/RESP_READY response handshake; RESP_RDATA/RESP_ERR payload
//   MEM_READ/MEM_WRITE    memory strobes
//   MEM_ADDR/MEM_WDATA    memory address and write data
//   MEM_RDATA             memory read data
//   ERR_CNT               saturating count of faulted requests
//   DBG_STATE             current FSM state (mem_pkg::state_t encoding)
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high; the sender holds its payload stable
// and keeps valid asserted until that edge.
module data_mem_ctrl
  import mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic [DATA_W-1:0] RESP_RDATA,
  output logic              RESP_ERR,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [7:0]        ERR_CNT,
  output logic [1:0]        DBG_STATE
);

  state_t r_state;
  logic   r_write;

  assign REQ_READY = (r_state == ST_IDLE);
  assign DBG_STATE = r_state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_RDATA <= '0;
      RESP_ERR   <= 1'b0;
      MEM_READ   <= 1'b0;
      MEM_WRITE  <= 1'b0;
      MEM_ADDR   <= PARK_ADDR;
      MEM_WDATA  <= '0;
      ERR_CNT    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            r_write <= REQ_WRITE;
            if (addr_in_range(REQ_ADDR)) begin
              // Address and strobe move together: the park->target change
              // is the event the memory acts on. MEM_ADDR/MEM_WDATA double
              // as the request latches for the rest of the access.
              r_state   <= ST_ISSUE;
              MEM_ADDR  <= REQ_ADDR;
              MEM_READ  <= ~REQ_WRITE;
              MEM_WRITE <= REQ_WRITE;
              if (REQ_WRITE) begin
                MEM_WDATA <= REQ_WDATA;
              end
            end else begin
              r_state    <= ST_RESP;
              RESP_VALID <= 1'b1;
              RESP_ERR   <= 1'b1;
              RESP_RDATA <= '0;
              if (ERR_CNT != 8'hFF) begin
                ERR_CNT <= ERR_CNT + 8'd1;
              end
            end
          end
        end

        ST_ISSUE: begin
          // Strobes drop while the address is held, so parking later
          // cannot be mistaken for a new access.
          r_state   <= ST_HOLD;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end

        ST_HOLD: begin
          r_state    <= ST_RESP;
          RESP_VALID <= 1'b1;
          RESP_ERR   <= 1'b0;
          RESP_RDATA <= r_write ? '0 : MEM_RDATA;
          MEM_ADDR   <= PARK_ADDR;
        end

        ST_RESP: begin
          if (RESP_READY) begin
            r_state    <= ST_IDLE;
            RESP_VALID <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_WRITE = 1'b0;
  logic [7:0] REQ_ADDR = '0;
  logic [7:0] REQ_WDATA = '0;
  logic       RESP_VALID;
  logic       RESP_READY = 1'b1;
  logic [7:0] RESP_RDATA;
  logic       RESP_ERR;
  logic       MEM_READ;
  logic       MEM_WRITE;
  logic [7:0] MEM_ADDR;
  logic [7:0] MEM_WDATA;
  logic [7:0] MEM_RDATA = '0;
  logic [7:0] ERR_CNT;
  logic [1:0] DBG_STATE;

  always #5 CLK = ~CLK;

  data_mem_ctrl dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .ERR_CNT(ERR_CNT), .DBG_STATE(DBG_STATE)
  );

  // ---------------- memory model ----------------
  // Acts only when the address changes; init pattern: a<16 -> a,
  // a>=16 -> (a-16)*8'h3B (addr 16 -> 00, addr 20 -> EC).
  logic [7:0] mem [32];
  bit         mem_ready = 1'b0;
  logic [7:0] prev_mem_addr = 8'hFF;
  int         acc_cnt = 0;

  always @(negedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= (i < 16) ? 8'(i) : 8'((i - 16) * 8'h3B);
      mem_ready <= 1'b1;
    end else if (MEM_ADDR != prev_mem_addr && MEM_ADDR < 8'd32) begin
      if (MEM_WRITE) mem[MEM_ADDR[4:0]] <= MEM_WDATA;
      if (MEM_READ)  MEM_RDATA <= mem[MEM_ADDR[4:0]];
      if (MEM_READ || MEM_WRITE) acc_cnt <= acc_cnt + 1;
    end
    prev_mem_addr <= MEM_ADDR;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns just after the accept edge.
  task automatic drive_req(input logic w, input logic [7:0] a, input logic [7:0] d);
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d;
    @(negedge CLK);
    check("req_ready_before_accept", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  // Full transaction with RESP_READY high; checks latency, strobes, payload.
  task automatic run_txn(input string name, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic exp_err, input logic [7:0] exp_rd);
    int cyc, rd_cyc, wr_cyc, acc0;
    logic prev_strobe;
    logic [7:0] prev_addr;
    bit got;
    RESP_READY = 1'b1;
    acc0 = acc_cnt;
    drive_req(w, a, d);
    cyc = 0; rd_cyc = 0; wr_cyc = 0; got = 0;
    prev_strobe = 1'b0; prev_addr = PARK_ADDR;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge CLK);
      if (MEM_READ)  rd_cyc++;
      if (MEM_WRITE) wr_cyc++;
      if (MEM_READ || MEM_WRITE) begin
        check({name, ":strobe_addr"}, 32'(MEM_ADDR), 32'(a));
        if (w) check({name, ":wdata"}, 32'(MEM_WDATA), 32'(d));
      end
      if (prev_strobe && !(MEM_READ || MEM_WRITE))
        check({name, ":addr_held_at_strobe_fall"}, 32'(MEM_ADDR), 32'(prev_addr));
      prev_strobe = MEM_READ || MEM_WRITE;
      prev_addr = MEM_ADDR;
      if (RESP_VALID) begin got = 1; cyc = c; end
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL %s:timeout actual=no_resp expected=resp", name);
    end else begin
      check({name, ":latency"}, 32'(cyc), exp_err ? 32'd1 : 32'd3);
      check({name, ":err"}, 32'(RESP_ERR), 32'(exp_err));
      check({name, ":rdata"}, 32'(RESP_RDATA), 32'(exp_rd));
      check({name, ":parked"}, 32'(MEM_ADDR), 32'(PARK_ADDR));
      check({name, ":rd_strobe_cycles"}, 32'(rd_cyc), (!w && !exp_err) ? 32'd1 : 32'd0);
      check({name, ":wr_strobe_cycles"}, 32'(wr_cyc), (w && !exp_err) ? 32'd1 : 32'd0);
      check({name, ":mem_events"}, 32'(acc_cnt - acc0), exp_err ? 32'd0 : 32'd1);
    end
    @(posedge CLK);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string      name;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"load5",       1'b0, 8'd5,   8'h00, 1'b0, 8'h05};
    vecs[1] = '{"load20_pre",  1'b0, 8'd20,  8'h00, 1'b0, 8'hEC};
    vecs[2] = '{"load16",      1'b0, 8'd16,  8'h00, 1'b0, 8'h00};
    vecs[3] = '{"store20",     1'b1, 8'd20,  8'hA5, 1'b0, 8'h00};
    vecs[4] = '{"load20_post", 1'b0, 8'd20,  8'h00, 1'b0, 8'hA5};
    vecs[5] = '{"load3_a",     1'b0, 8'd3,   8'h00, 1'b0, 8'h03};
    vecs[6] = '{"load3_b",     1'b0, 8'd3,   8'h00, 1'b0, 8'h03};
    vecs[7] = '{"load32_err",  1'b0, 8'd32,  8'h00, 1'b1, 8'h00};
    vecs[8] = '{"store200_err",1'b1, 8'd200, 8'h77, 1'b1, 8'h00};

    // reset
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_req_ready", 32'(REQ_READY), 32'd1);
    check("rst_resp_valid", 32'(RESP_VALID), 32'd0);
    check("rst_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
    check("rst_mem_addr", 32'(MEM_ADDR), 32'(PARK_ADDR));
    check("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);
    check("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    check("rst_state", 32'(DBG_STATE), 32'd0);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].name, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_err, vecs[i].exp_rd);
    @(negedge CLK);
    check("err_cnt_after_faults", 32'(ERR_CNT), 32'd2);
    @(posedge CLK);
    #1;

    // stall: load addr 9, RESP_READY low for 5 cycles
    exp_q.push_back(8'h09);
    RESP_READY = 1'b0;
    drive_req(1'b0, 8'd9, 8'h00);
    repeat (3) @(negedge CLK);
    check("stall_resp_valid_k3", 32'(RESP_VALID), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(RESP_VALID), 32'd1);
      check("stall_rdata", 32'(RESP_RDATA), 32'(exp_q[0]));
      check("stall_req_ready", 32'(REQ_READY), 32'd0);
      @(negedge CLK);
    end
    void'(exp_q.pop_front());
    @(posedge CLK);
    #1 RESP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("stall_back_idle", 32'(REQ_READY), 32'd1);
    check("stall_valid_dropped", 32'(RESP_VALID), 32'd0);
    @(posedge CLK);
    #1;

    // reset during ISSUE of a store to addr 7
    drive_req(1'b1, 8'd7, 8'h11);
    @(negedge CLK);
    check("rstmid_in_issue", 32'(MEM_WRITE), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rstmid_state", 32'(DBG_STATE), 32'd0);
    check("rstmid_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
    check("rstmid_mem_addr", 32'(MEM_ADDR), 32'(PARK_ADDR));
    check("rstmid_resp_valid", 32'(RESP_VALID), 32'd0);
    check("rstmid_err_cnt", 32'(ERR_CNT), 32'd0);
    @(posedge CLK);
    #1;
    // the store already issued is not rolled back
    run_txn("load7_after_rst", 1'b0, 8'd7, 8'h00, 1'b0, 8'h11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
